// File: rtl/bus_grant_scheduler.sv
// Round-robin owner selection for a shared tri-state bus, with a one-cycle turnaround between owners.
// Define ARB_TIMEOUT_EN to compile a hold timer that revokes a grant after TIMEOUT_CYCLES cycles.
module bus_grant_scheduler #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] done,
   output logic [2:0] sel,
   output logic       en_n,
   output logic [7:0] grant,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t     state;
   logic [2:0] last_owner;
   logic [3:0] pick;
   logic       release_bus;

   // Returns {found, index}. The search begins one past the last owner. It is
   // walked in reverse so that the closest requester is written last and wins.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
      logic [2:0] idx;
      rr_pick = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         idx = last + 3'(i);
         if (r[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

   assign pick        = rr_pick(req, last_owner);
   assign release_bus = done[sel] | ~req[sel];

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] timer;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= 3'd0;
         en_n       <= 1'b1;
         grant      <= 8'h00;
         busy       <= 1'b0;
         timeout    <= 1'b0;
         last_owner <= 3'd7;
`ifdef ARB_TIMEOUT_EN
         timer      <= '0;
`endif
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE, TURN: begin
               if (pick[3]) begin
                  state      <= GRANT;
                  sel        <= pick[2:0];
                  last_owner <= pick[2:0];
                  en_n       <= 1'b0;
                  grant      <= 8'b1 << pick[2:0];
                  busy       <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  timer      <= '0;
`endif
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            GRANT: begin
               if (release_bus) begin
                  state <= TURN;
                  en_n  <= 1'b1;
                  grant <= 8'h00;
               end
`ifdef ARB_TIMEOUT_EN
               else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state   <= TURN;
                  en_n    <= 1'b1;
                  grant   <= 8'h00;
                  timeout <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
`endif
            end
            default: begin
               state <= IDLE;
               en_n  <= 1'b1;
               grant <= 8'h00;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
